// File: rtl/connect4_pkg.sv
// Shared Connect4 codes and board geometry, used by the controller, the height
// tracker and the LED status display.
package connect4_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    STILL_PLAYING = 2'b00,
    P1_WINS       = 2'b01,
    P2_WINS       = 2'b10,
    TIE           = 2'b11
  } game_status_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  function automatic cell_t player_cell(input logic player);
    return player ? P2 : P1;
  endfunction

  function automatic game_state_t turn_code(input logic player);
    return player ? P2_TURN : P1_TURN;
  endfunction

endpackage

// File: rtl/connect4_game_controller_heights.sv
// Per-column fill heights. Heights saturate at ROWS; an out-of-range column
// reads as full so the controller treats it like any other rejected drop.
module column_height_tracker
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       inc,
  input  logic [2:0] col,
  output logic [2:0] height,
  output logic       full
);

  logic [COLS*3-1:0] heights_flat;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [2:0] height_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          height_reg <= '0;
        end else if (clear) begin
          height_reg <= '0;
        end else if (inc && col == 3'(gi) && height_reg < 3'(ROWS)) begin
          height_reg <= height_reg + 3'd1;
        end
      end

      assign heights_flat[gi*3 +: 3] = height_reg;
    end
  endgenerate

  always_comb begin
    height = '0;
    full   = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      if (col == 3'(i)) begin
        height = heights_flat[i*3 +: 3];
        full   = (heights_flat[i*3 +: 3] >= 3'(ROWS));
      end
    end
  end

endmodule

// File: rtl/connect4_game_controller.sv
// Connect4 turn sequencer: clears the board, validates drops, writes pieces and
// hands each move to the external win checker. All outputs are registered.
module connect4_game_controller
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       drop,
  input  logic [2:0] col,
  input  logic       check_done,
  input  logic       check_win,
  output logic       board_we,
  output logic [2:0] board_row,
  output logic [2:0] board_col,
  output logic [1:0] board_data,
  output logic       check_start,
  output logic       move_illegal,
  output logic [1:0] state,
  output logic [1:0] game_status
);

  typedef enum logic [2:0] {
    S_INIT, S_CLEAR, S_TURN, S_WRITE, S_CHECK, S_END
  } fsm_t;

  fsm_t       fsm_reg;
  logic       player_reg;
  logic [5:0] move_cnt_reg;
  logic [5:0] clear_idx_reg;

  logic [2:0] col_height;
  logic       col_full;
  logic       start_ok;
  logic       drop_ok;

  assign start_ok = start && (fsm_reg == S_INIT || fsm_reg == S_END);
  assign drop_ok  = drop && (fsm_reg == S_TURN) && !col_full;

  column_height_tracker u_heights (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_ok),
    .inc     (drop_ok),
    .col     (col),
    .height  (col_height),
    .full    (col_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_reg       <= S_INIT;
      player_reg    <= 1'b0;
      move_cnt_reg  <= '0;
      clear_idx_reg <= '0;
      board_we      <= 1'b0;
      board_row     <= '0;
      board_col     <= '0;
      board_data    <= '0;
      check_start   <= 1'b0;
      move_illegal  <= 1'b0;
      state         <= GAME_INIT;
      game_status   <= STILL_PLAYING;
    end else begin
      board_we     <= 1'b0;
      check_start  <= 1'b0;
      move_illegal <= 1'b0;
      case (fsm_reg)
        S_INIT, S_END: begin
          // start takes priority over a simultaneous drop, which is ignored here
          if (start) begin
            fsm_reg       <= S_CLEAR;
            state         <= GAME_INIT;
            game_status   <= STILL_PLAYING;
            move_cnt_reg  <= '0;
            clear_idx_reg <= '0;
            board_we      <= 1'b1;
            board_row     <= '0;
            board_col     <= '0;
            board_data    <= EMPTY;
          end
        end
        S_CLEAR: begin
          if (clear_idx_reg == 6'(CELLS - 1)) begin
            fsm_reg    <= S_TURN;
            player_reg <= 1'b0;
            state      <= P1_TURN;
          end else begin
            clear_idx_reg <= clear_idx_reg + 6'd1;
            board_we      <= 1'b1;
            if (board_col == 3'(COLS - 1)) begin
              board_col <= '0;
              board_row <= board_row + 3'd1;
            end else begin
              board_col <= board_col + 3'd1;
            end
          end
        end
        S_TURN: begin
          if (drop) begin
            if (!col_full) begin
              fsm_reg      <= S_WRITE;
              board_we     <= 1'b1;
              board_row    <= col_height;
              board_col    <= col;
              board_data   <= player_cell(player_reg);
              move_cnt_reg <= move_cnt_reg + 6'd1;
            end else begin
              move_illegal <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          fsm_reg     <= S_CHECK;
          check_start <= 1'b1;
        end
        S_CHECK: begin
          // a win on the final move outranks the full-board tie
          if (check_done) begin
            if (check_win) begin
              fsm_reg     <= S_END;
              state       <= END_GAME;
              game_status <= player_reg ? P2_WINS : P1_WINS;
            end else if (move_cnt_reg == 6'(CELLS)) begin
              fsm_reg     <= S_END;
              state       <= END_GAME;
              game_status <= TIE;
            end else begin
              fsm_reg    <= S_TURN;
              player_reg <= ~player_reg;
              state      <= turn_code(~player_reg);
            end
          end
        end
        default: fsm_reg <= S_INIT;
      endcase
    end
  end

endmodule
